// File: rtl/common.sv
// Shared data-bus types exchanged between the memory stage and the data responder.
// Latency: none, types only.
// Backpressure: none, types only.
package common;

  // Access width of a data-bus request, encoded as log2 of the byte count.
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-side helpers for the data responder: FSM state type and size decoding.
// Latency: none, types and pure functions only.
// Backpressure: none, types and pure functions only.
package pipes;
  import common::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_t;

  // Number of bytes touched by an access of the given size.
  function automatic logic [3:0] size_bytes(input msize_t size);
    case (size)
      MSIZE1:  return 4'd1;
      MSIZE2:  return 4'd2;
      MSIZE4:  return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// Data-bus request/response bundle between the memory stage and the responder.
// Latency: wires only.
// Backpressure: none on the bus itself; the responder simply ignores requests while busy.
interface dbus_responder_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic       misalign;

  modport master (output dreq, input dresp, input misalign);
  modport slave  (input dreq, output dresp, output misalign);

endinterface

// File: rtl/dbus_resp_ram.sv
// DEPTH x 64-bit data RAM, asynchronous read port and 8-lane byte-strobe write port.
// Latency: read is combinational; write lands on the rising clock edge.
// Backpressure: none; contents are never cleared by reset.
module dbus_resp_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    strobe,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  logic [63:0] mem [DEPTH];

  assign rdata = mem[raddr];

  // Byte-lane write: only lanes with their strobe bit set are updated.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: captures one request, waits LATENCY cycles, answers from a DEPTH x 64 RAM.
// Latency: data_ok in cycle LATENCY+1 after valid is first seen; next request accepted from LATENCY+2.
// Backpressure: none; valid dropped while waiting abandons the request. Option: DBUS_MISALIGN_CHECK_EN.
module dbus_responder
  import common::*;
  import pipes::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input logic             clk,
  input logic             reset,
  dbus_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  resp_state_t state;
  logic [3:0]  cnt;
  logic [63:0] cap_addr;
  msize_t      cap_size;
  logic [7:0]  cap_strobe;
  logic [63:0] cap_data;

  logic          in_resp;
  logic          mis_hit;
  logic          ram_we;
  logic [AW-1:0] cap_idx;
  logic [63:0]   ram_rdata;

  // Request FSM: capture in IDLE, count down in WAIT, answer for one cycle in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_addr   <= '0;
      cap_size   <= MSIZE1;
      cap_strobe <= '0;
      cap_data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.dreq.valid) begin
            cap_addr   <= bus.dreq.addr;
            cap_size   <= bus.dreq.size;
            cap_strobe <= bus.dreq.strobe;
            cap_data   <= bus.dreq.data;
            if (LATENCY > 0) begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          // The requester may withdraw while we wait; drop the access silently.
          if (!bus.dreq.valid) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_resp = (state == RESP);
  assign cap_idx = cap_addr[3 +: AW];

`ifdef DBUS_MISALIGN_CHECK_EN
  logic [3:0] nbytes;
  assign nbytes  = size_bytes(cap_size);
  assign mis_hit = |(cap_addr[2:0] & 3'(nbytes - 4'd1));
  logic unused_addr_hi;
  assign unused_addr_hi = ^cap_addr[63:AW+3];
`else
  assign mis_hit = 1'b0;
  logic unused_cap;
  assign unused_cap = ^{cap_addr[63:AW+3], cap_addr[2:0], cap_size};
`endif

  // A reset landing on the response edge must not commit the write.
  assign ram_we = in_resp && !reset && !mis_hit;

  dbus_resp_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .waddr  (cap_idx),
    .strobe (cap_strobe),
    .wdata  (cap_data),
    .raddr  (cap_idx),
    .rdata  (ram_rdata)
  );

  assign bus.dresp.addr_ok = in_resp;
  assign bus.dresp.data_ok = in_resp;
  assign bus.dresp.data    = (in_resp && !mis_hit) ? ram_rdata : 64'd0;
  assign bus.misalign      = in_resp && mis_hit;

endmodule
